// File: rtl/j1_types.sv
// ---------------------------------------------------------------------------
// j1_types
// Shared types for the J1 Wishbone master arbiter.
//   arb_state_t : arbiter FSM states (idle, bus cycle active, response cycle)
//   arb_grant_t : which requester path owns / last owned the bus
//   WB_DW       : Wishbone data width
// ---------------------------------------------------------------------------
package j1_types;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUS, ARB_RESP} arb_state_t;
  typedef enum logic {GNT_FETCH, GNT_DATA} arb_grant_t;

  localparam int unsigned WB_DW = 16;

endpackage

// File: rtl/j1_wb_timeout.sv
// ---------------------------------------------------------------------------
// j1_wb_timeout
// Bus watchdog for the J1 Wishbone arbiter. Counts cycles while `run` is
// high and raises `expired` in the LIMIT-th consecutive running cycle.
// Compiled only when J1_WB_TIMEOUT_EN is defined (the only build that
// instantiates it).
// Ports:
//   clk_i   in  clock
//   rst_ni  in  asynchronous active-low reset
//   clear   in  zero the counter (held while the bus is idle)
//   run     in  count this cycle (bus cycle outstanding)
//   expired out high in the LIMIT-th running cycle
// ---------------------------------------------------------------------------
`ifdef J1_WB_TIMEOUT_EN
module j1_wb_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic run,
  output logic expired
);

  // Counter only needs to reach LIMIT-1.
  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Counter value k means this is the (k+1)-th running cycle.
  assign expired = run && (r_cnt == LAST);

endmodule
`endif

// File: rtl/j1_wb_arbiter.sv
// ---------------------------------------------------------------------------
// j1_wb_arbiter
// Round-robin arbiter sharing one 16-bit Wishbone B3 classic master port
// between the J1 instruction-fetch path (read-only) and the data path.
// One transaction in flight; every transaction ends with a registered
// one-cycle *_ack (with *_err qualifying it). All outputs are registered.
// Optional feature: define J1_WB_TIMEOUT_EN to add a watchdog that ends a
// bus cycle with an error after TIMEOUT cycles without termination.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   if_req/if_addr -> if_data/if_ack/if_err            fetch path
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack/d_err   data path
//   cyc_o/stb_o/we_o/adr_o/dat_o, dat_i/ack_i/err_i    Wishbone master
// ---------------------------------------------------------------------------
module j1_wb_arbiter
  import j1_types::*;
#(
  parameter int unsigned AW      = 15,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic [WB_DW-1:0] if_data,
  output logic             if_ack,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [WB_DW-1:0] d_wdata,
  output logic [WB_DW-1:0] d_rdata,
  output logic             d_ack,
  output logic             d_err,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [AW-1:0]    adr_o,
  output logic [WB_DW-1:0] dat_o,
  input  logic [WB_DW-1:0] dat_i,
  input  logic             ack_i,
  input  logic             err_i
);

  arb_state_t       r_state, w_state_next;
  arb_grant_t       r_grant, w_grant_next;
  arb_grant_t       r_last,  w_last_next;
  arb_grant_t       w_winner;
  logic             r_cyc, w_cyc_next;
  logic             r_we, w_we_next;
  logic [AW-1:0]    r_adr, w_adr_next;
  logic [WB_DW-1:0] r_dat, w_dat_next;
  logic [WB_DW-1:0] r_if_data, w_if_data_next;
  logic             r_if_ack, w_if_ack_next;
  logic             r_if_err, w_if_err_next;
  logic [WB_DW-1:0] r_d_data, w_d_data_next;
  logic             r_d_ack, w_d_ack_next;
  logic             r_d_err, w_d_err_next;
  logic             w_expired;
  logic             w_bus_err;
  logic [WB_DW-1:0] w_bus_rdata;

`ifdef J1_WB_TIMEOUT_EN
  // Cleared for the whole idle period, so it starts from zero on entry to BUS.
  j1_wb_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (r_state == ARB_IDLE),
    .run     (r_state == ARB_BUS),
    .expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expired        = 1'b0;
`endif

  // A termination beats a simultaneous watchdog expiry; err_i beats ack_i.
  // Anything other than a clean ack is an error.
  assign w_bus_err   = err_i || !ack_i;
  // A watchdog ending returns zero rather than whatever is on dat_i.
  assign w_bus_rdata = (ack_i || err_i) ? dat_i : '0;

  // Round-robin: on contention the path that did not win last time goes.
  always_comb begin
    w_winner = GNT_FETCH;
    if (if_req && d_req) begin
      w_winner = (r_last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (d_req) begin
      w_winner = GNT_DATA;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_last_next    = r_last;
    w_cyc_next     = r_cyc;
    w_we_next      = r_we;
    w_adr_next     = r_adr;
    w_dat_next     = r_dat;
    w_if_data_next = r_if_data;
    w_d_data_next  = r_d_data;
    w_if_ack_next  = 1'b0;
    w_if_err_next  = 1'b0;
    w_d_ack_next   = 1'b0;
    w_d_err_next   = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          w_state_next = ARB_BUS;
          w_grant_next = w_winner;
          w_last_next  = w_winner;
          w_cyc_next   = 1'b1;
          if (w_winner == GNT_DATA) begin
            w_we_next  = d_we;
            w_adr_next = d_addr;
            w_dat_next = d_wdata;
          end else begin
            w_we_next  = 1'b0;
            w_adr_next = if_addr;
            w_dat_next = '0;
          end
        end
      end

      ARB_BUS: begin
        if (ack_i || err_i || w_expired) begin
          w_state_next = ARB_RESP;
          w_cyc_next   = 1'b0;
          // Ack/err registered here so they are high exactly during RESP.
          if (r_grant == GNT_FETCH) begin
            w_if_ack_next = 1'b1;
            w_if_err_next = w_bus_err;
            if (!r_we) begin
              w_if_data_next = w_bus_rdata;
            end
          end else begin
            w_d_ack_next = 1'b1;
            w_d_err_next = w_bus_err;
            if (!r_we) begin
              w_d_data_next = w_bus_rdata;
            end
          end
        end
      end

      ARB_RESP: begin
        // Requests are deliberately ignored here; requesters drop req now.
        w_state_next = ARB_IDLE;
      end

      default: begin
        w_state_next = ARB_IDLE;
        w_cyc_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ARB_IDLE;
      r_grant   <= GNT_FETCH;
      r_last    <= GNT_DATA;   // first contended grant goes to fetch
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_if_data <= '0;
      r_if_ack  <= 1'b0;
      r_if_err  <= 1'b0;
      r_d_data  <= '0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_last    <= w_last_next;
      r_cyc     <= w_cyc_next;
      r_we      <= w_we_next;
      r_adr     <= w_adr_next;
      r_dat     <= w_dat_next;
      r_if_data <= w_if_data_next;
      r_if_ack  <= w_if_ack_next;
      r_if_err  <= w_if_err_next;
      r_d_data  <= w_d_data_next;
      r_d_ack   <= w_d_ack_next;
      r_d_err   <= w_d_err_next;
    end
  end

  assign cyc_o   = r_cyc;
  assign stb_o   = r_cyc;
  assign we_o    = r_we;
  assign adr_o   = r_adr;
  assign dat_o   = r_dat;
  assign if_data = r_if_data;
  assign if_ack  = r_if_ack;
  assign if_err  = r_if_err;
  assign d_rdata = r_d_data;
  assign d_ack   = r_d_ack;
  assign d_err   = r_d_err;

endmodule

// File: tb/tb_j1_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_j1_wb_arbiter
// Scoreboard bench for j1_wb_arbiter. Expected completions are queued when a
// request is issued; a negedge monitor pops and compares on each ack and
// checks the bus signals against the queue head while cyc_o is high.
// Watchdog scenario runs when J1_WB_TIMEOUT_EN is defined (TIMEOUT = 8).
// ---------------------------------------------------------------------------
module tb_j1_wb_arbiter;

  localparam int AW = 15;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [15:0]   if_data;
  logic          if_ack, if_err;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [15:0]   d_wdata = '0;
  logic [15:0]   d_rdata;
  logic          d_ack, d_err;
  logic          cyc_o, stb_o, we_o;
  logic [AW-1:0] adr_o;
  logic [15:0]   dat_o;
  logic [15:0]   dat_i = 16'hDEAD;
  logic          ack_i = 1'b0;
  logic          err_i = 1'b0;

  j1_wb_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
    .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int slave_wait = 0;
  bit slave_err  = 1'b0;
  bit slave_hang = 1'b0;

  function automatic logic [15:0] slave_data(input logic [AW-1:0] a);
    if (a == 15'h0010) return 16'h8005;
    return 16'(a) ^ 16'h5A5A;
  endfunction

  initial begin
    int ws;
    ws = 0;
    forever begin
      @(posedge clk_i); #1;
      if (ack_i || err_i) begin
        ack_i = 1'b0; err_i = 1'b0; dat_i = 16'hDEAD; ws = 0;
      end else if (!cyc_o) begin
        ws = 0;
      end else if (!slave_hang) begin
        if (ws >= slave_wait) begin
          ack_i = 1'b1;
          err_i = slave_err;
          dat_i = slave_data(adr_o);
        end else begin
          ws++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          path;     // 0 fetch, 1 data
    bit          we;
    logic [14:0] adr;
    logic [15:0] wd;
    logic [15:0] data;
    bit          err;
    int          clen;
  } exp_t;

  exp_t sb[$];
  logic [15:0] mdl_if_data = '0;
  logic [15:0] mdl_d_data  = '0;

  task automatic push_exp(input bit path, input bit we, input logic [14:0] adr,
                          input logic [15:0] wd, input bit err, input int clen,
                          input bit zero_data);
    exp_t e;
    e.path = path; e.we = we; e.adr = adr; e.wd = wd; e.err = err; e.clen = clen;
    if (we) begin
      e.data = path ? mdl_d_data : mdl_if_data;
    end else begin
      e.data = zero_data ? 16'h0000 : slave_data(adr);
      if (path) mdl_d_data = e.data; else mdl_if_data = e.data;
    end
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    int   cyc_cnt;
    exp_t e;
    cyc_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        cyc_cnt = 0;
      end else begin
        if (cyc_o) begin
          cyc_cnt++;
          check_val("stb_eq_cyc", stb_o, cyc_o);
          if (sb.size() > 0) begin
            check_val("bus_adr", adr_o, sb[0].adr);
            check_val("bus_we", we_o, sb[0].we);
            if (sb[0].we) check_val("bus_dat", dat_o, sb[0].wd);
          end
        end
        if (if_ack || d_ack) begin
          if (sb.size() == 0) begin
            check_val("unexpected_ack", {if_ack, d_ack}, 2'b00);
          end else begin
            e = sb.pop_front();
            check_val("ack_path", {if_ack, d_ack}, e.path ? 2'b01 : 2'b10);
            check_val("rdata", e.path ? d_rdata : if_data, e.data);
            check_val("err", e.path ? d_err : if_err, e.err);
            check_val("cyc_len", cyc_cnt, e.clen);
            $display("txn path=%s we=%0d adr=0x%04h data=0x%04h err=%0d cyc=%0d",
                     e.path ? "data" : "fetch", e.we, e.adr,
                     e.path ? d_rdata : if_data, e.path ? d_err : if_err, cyc_cnt);
          end
          cyc_cnt = 0;
        end
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic wait_ack(input bit path);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (path ? d_ack : if_ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val(path ? "d_ack_wait" : "if_ack_wait", 0, 1);
  endtask

  task automatic fetch(input logic [14:0] a);
    @(posedge clk_i); #1;
    if_addr = a; if_req = 1'b1;
    wait_ack(1'b0);
    if_req = 1'b0;   // dropped in the ack cycle
  endtask

  task automatic data_xfer(input bit we, input logic [14:0] a, input logic [15:0] wd);
    @(posedge clk_i); #1;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    wait_ack(1'b1);
    d_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk_i);
    check_val("reset_ctrl", {cyc_o, stb_o, we_o, if_ack, if_err, d_ack, d_err, adr_o, dat_o}, 0);
    check_val("reset_if_data", if_data, 0);
    check_val("reset_d_rdata", d_rdata, 0);
    rst_ni = 1'b1;

    // Lone fetch, zero-wait slave.
    slave_wait = 0;
    push_exp(1'b0, 1'b0, 15'h0010, 16'h0, 1'b0, 1, 1'b0);
    fetch(15'h0010);

    // Data write, 3 wait states: rdata still at its reset value.
    slave_wait = 3;
    push_exp(1'b1, 1'b1, 15'h4000, 16'h1234, 1'b0, 4, 1'b0);
    data_xfer(1'b1, 15'h4000, 16'h1234);

    // Data read, then a write that must leave d_rdata holding the read value.
    slave_wait = 1;
    push_exp(1'b1, 1'b0, 15'h0100, 16'h0, 1'b0, 2, 1'b0);
    data_xfer(1'b0, 15'h0100, 16'h0);
    slave_wait = 0;
    push_exp(1'b1, 1'b1, 15'h0101, 16'hBEEF, 1'b0, 1, 1'b0);
    data_xfer(1'b1, 15'h0101, 16'hBEEF);

    // Contention: expected grant order fetch, data, fetch.
    repeat (2) @(negedge clk_i);
    push_exp(1'b0, 1'b0, 15'h0A00, 16'h0, 1'b0, 1, 1'b0);
    push_exp(1'b1, 1'b0, 15'h0B00, 16'h0, 1'b0, 1, 1'b0);
    push_exp(1'b0, 1'b0, 15'h0C00, 16'h0, 1'b0, 1, 1'b0);
    fork
      begin fetch(15'h0A00); fetch(15'h0C00); end
      data_xfer(1'b0, 15'h0B00, 16'h0);
    join

    // err_i together with ack_i on a data read.
    slave_err = 1'b1; slave_wait = 2;
    push_exp(1'b1, 1'b0, 15'h0300, 16'h0, 1'b1, 3, 1'b0);
    data_xfer(1'b0, 15'h0300, 16'h0);
    slave_err = 1'b0; slave_wait = 0;

    // Reset in the middle of a stalled bus cycle.
    slave_hang = 1'b1;
    @(posedge clk_i); #1;
    d_we = 1'b0; d_addr = 15'h0200; d_req = 1'b1;
    repeat (3) @(negedge clk_i);
    check_val("rst_pre_cyc", cyc_o, 1);
    #2 rst_ni = 1'b0;
    #1 check_val("rst_async_cyc", {cyc_o, stb_o}, 2'b00);
    d_req = 1'b0; slave_hang = 1'b0;
    mdl_if_data = '0; mdl_d_data = '0;
    repeat (2) @(negedge clk_i);
    check_val("rst_outs", {cyc_o, if_ack, d_ack, if_data, d_rdata}, 0);
    rst_ni = 1'b1;

    // Clean restart after the abort.
    push_exp(1'b0, 1'b0, 15'h0040, 16'h0, 1'b0, 1, 1'b0);
    fetch(15'h0040);
    push_exp(1'b1, 1'b1, 15'h0041, 16'h5555, 1'b0, 1, 1'b0);
    data_xfer(1'b1, 15'h0041, 16'h5555);

`ifdef J1_WB_TIMEOUT_EN
    // Slave never answers: watchdog ends the cycle after TO cycles.
    slave_hang = 1'b1;
    push_exp(1'b0, 1'b0, 15'h0020, 16'h0, 1'b1, TO, 1'b1);
    fetch(15'h0020);
    slave_hang = 1'b0;
`endif

    repeat (3) @(negedge clk_i);
    check_val("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
